// File: rtl/cmd_issuer.sv
// DDR command issuer: pops {cmd,addr,bank} entries, waits out tRCD/tRP/tRFC/tCCD, drives pins.
// Codes: NOP 0, ACT 1, RD 2, WR 3, RDA 4, WRA 5, PRE 6, PREA 7, REF 8. Option: CMD_ISSUER_SEQ_CHK_EN.
module cmd_issuer #(
   parameter int unsigned ADDR_BITS = 14,
   parameter int unsigned BA_BITS   = 3,
   parameter int unsigned CMD_W     = 4,
   parameter int unsigned T_RCD     = 4,
   parameter int unsigned T_RP      = 4,
   parameter int unsigned T_RFC     = 32,
   parameter int unsigned T_CCD     = 2
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               isu_fifo_empty,
   input  logic [CMD_W+ADDR_BITS+BA_BITS-1:0] isu_fifo_dout,
   output logic                               isu_fifo_rd,
   output logic                               cs_n,
   output logic                               ras_n,
   output logic                               cas_n,
   output logic                               we_n,
   output logic [ADDR_BITS-1:0]               dram_addr,
   output logic [BA_BITS-1:0]                 dram_ba,
   output logic                               rd_issued,
   output logic                               wr_issued,
   output logic                               busy,
   output logic                               seq_err
);

   localparam int unsigned EntW = CMD_W + ADDR_BITS + BA_BITS;
   localparam int unsigned CntW = $clog2(T_RFC + T_RP + T_CCD + 1);

   localparam logic [CMD_W-1:0] CmdAct  = CMD_W'(1);
   localparam logic [CMD_W-1:0] CmdRd   = CMD_W'(2);
   localparam logic [CMD_W-1:0] CmdWr   = CMD_W'(3);
   localparam logic [CMD_W-1:0] CmdRda  = CMD_W'(4);
   localparam logic [CMD_W-1:0] CmdWra  = CMD_W'(5);
   localparam logic [CMD_W-1:0] CmdPre  = CMD_W'(6);
   localparam logic [CMD_W-1:0] CmdPrea = CMD_W'(7);
   localparam logic [CMD_W-1:0] CmdRef  = CMD_W'(8);

   localparam logic [ADDR_BITS-1:0] A10 = ADDR_BITS'(1) << 10;

   localparam logic [CntW-1:0] LdRcd = CntW'(T_RCD - 1);
   localparam logic [CntW-1:0] LdRp  = CntW'(T_RP - 1);
   localparam logic [CntW-1:0] LdRpa = CntW'(T_RP + T_CCD - 1);
   localparam logic [CntW-1:0] LdRfc = CntW'(T_RFC - 1);
   localparam logic [CntW-1:0] LdCcd = CntW'(T_CCD - 1);

   typedef enum logic [1:0] {StIdle, StFetch, StWait, StIssue} state_e;

   state_e               state_q;
   logic [CMD_W-1:0]     cmd_q;
   logic [ADDR_BITS-1:0] addr_q;
   logic [BA_BITS-1:0]   ba_q;
   logic [CntW-1:0]      cnt_rcd_q, cnt_rp_q, cnt_rfc_q, cnt_ccd_q;
   logic [CntW-1:0]      cnt_rcd_d, cnt_rp_d, cnt_rfc_d, cnt_ccd_d;

   logic [CMD_W-1:0]     ent_cmd, cur_cmd;
   logic [ADDR_BITS-1:0] ent_addr, cur_addr, p_addr;
   logic [BA_BITS-1:0]   ent_ba, cur_ba, p_ba;
   logic [2:0]           p_rcw;
   logic                 p_rd, p_wr, known, ready, go;
   logic                 rcd_ok, rp_ok, rfc_ok, ccd_ok;

   assign ent_cmd  = isu_fifo_dout[EntW-1 -: CMD_W];
   assign ent_addr = isu_fifo_dout[BA_BITS +: ADDR_BITS];
   assign ent_ba   = isu_fifo_dout[BA_BITS-1:0];

   // In FETCH the entry is not latched yet, so decode straight from the FIFO output.
   assign cur_cmd  = (state_q == StFetch) ? ent_cmd  : cmd_q;
   assign cur_addr = (state_q == StFetch) ? ent_addr : addr_q;
   assign cur_ba   = (state_q == StFetch) ? ent_ba   : ba_q;

   // A count of 1 reaches 0 in the cycle the command would appear on the pins.
   assign rcd_ok = (cnt_rcd_q <= CntW'(1));
   assign rp_ok  = (cnt_rp_q  <= CntW'(1));
   assign rfc_ok = (cnt_rfc_q <= CntW'(1));
   assign ccd_ok = (cnt_ccd_q <= CntW'(1));

   always_comb begin
      known  = 1'b1;
      ready  = 1'b1;
      p_rcw  = 3'b111;
      p_addr = '0;
      p_ba   = cur_ba;
      p_rd   = 1'b0;
      p_wr   = 1'b0;
      case (cur_cmd)
         CmdAct: begin
            p_rcw  = 3'b011;
            p_addr = cur_addr;
            ready  = rp_ok && rfc_ok;
         end
         CmdRd, CmdRda: begin
            p_rcw  = 3'b101;
            p_addr = (cur_addr & ~A10) | ((cur_cmd == CmdRda) ? A10 : '0);
            p_rd   = 1'b1;
            ready  = rcd_ok && ccd_ok && rfc_ok;
         end
         CmdWr, CmdWra: begin
            p_rcw  = 3'b100;
            p_addr = (cur_addr & ~A10) | ((cur_cmd == CmdWra) ? A10 : '0);
            p_wr   = 1'b1;
            ready  = rcd_ok && ccd_ok && rfc_ok;
         end
         CmdPre: begin
            p_rcw = 3'b010;
            ready = rfc_ok;
         end
         CmdPrea: begin
            p_rcw  = 3'b010;
            p_addr = A10;
            p_ba   = '0;
            ready  = rfc_ok;
         end
         CmdRef: begin
            p_rcw = 3'b001;
            p_ba  = '0;
            ready = rp_ok && rfc_ok;
         end
         default: known = 1'b0;
      endcase
   end

   assign go = ((state_q == StFetch) && known && ready) || ((state_q == StWait) && ready);

   function automatic logic [CntW-1:0] dec(input logic [CntW-1:0] c);
      return (c == '0) ? c : c - CntW'(1);
   endfunction

   function automatic logic [CntW-1:0] max2(input logic [CntW-1:0] a, input logic [CntW-1:0] b);
      return (a > b) ? a : b;
   endfunction

   always_comb begin
      cnt_rcd_d = dec(cnt_rcd_q);
      cnt_rp_d  = dec(cnt_rp_q);
      cnt_rfc_d = dec(cnt_rfc_q);
      cnt_ccd_d = dec(cnt_ccd_q);
      if (state_q == StIssue) begin
         case (cmd_q)
            CmdAct:          cnt_rcd_d = max2(cnt_rcd_d, LdRcd);
            CmdRd, CmdWr:    cnt_ccd_d = max2(cnt_ccd_d, LdCcd);
            CmdRda, CmdWra: begin
               cnt_ccd_d = max2(cnt_ccd_d, LdCcd);
               cnt_rp_d  = max2(cnt_rp_d, LdRpa);
            end
            CmdPre, CmdPrea: cnt_rp_d  = max2(cnt_rp_d, LdRp);
            CmdRef:          cnt_rfc_d = max2(cnt_rfc_d, LdRfc);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_rcd_q <= '0;
         cnt_rp_q  <= '0;
         cnt_rfc_q <= '0;
         cnt_ccd_q <= '0;
      end else begin
         cnt_rcd_q <= cnt_rcd_d;
         cnt_rp_q  <= cnt_rp_d;
         cnt_rfc_q <= cnt_rfc_d;
         cnt_ccd_q <= cnt_ccd_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cmd_q       <= '0;
         addr_q      <= '0;
         ba_q        <= '0;
         isu_fifo_rd <= 1'b0;
         cs_n        <= 1'b1;
         ras_n       <= 1'b1;
         cas_n       <= 1'b1;
         we_n        <= 1'b1;
         dram_addr   <= '0;
         dram_ba     <= '0;
         rd_issued   <= 1'b0;
         wr_issued   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         isu_fifo_rd <= 1'b0;
         cs_n        <= 1'b1;
         ras_n       <= 1'b1;
         cas_n       <= 1'b1;
         we_n        <= 1'b1;
         dram_addr   <= '0;
         dram_ba     <= '0;
         rd_issued   <= 1'b0;
         wr_issued   <= 1'b0;
         case (state_q)
            StIdle: begin
               if (isu_fifo_rd) begin
                  state_q <= StFetch;
                  busy    <= 1'b1;
               end else begin
                  isu_fifo_rd <= !isu_fifo_empty;
               end
            end
            StFetch: begin
               cmd_q  <= ent_cmd;
               addr_q <= ent_addr;
               ba_q   <= ent_ba;
               if (!known) begin
                  state_q     <= StIdle;
                  busy        <= 1'b0;
                  isu_fifo_rd <= !isu_fifo_empty;
               end else if (ready) begin
                  state_q <= StIssue;
               end else begin
                  state_q <= StWait;
               end
            end
            StWait: if (ready) state_q <= StIssue;
            StIssue: begin
               state_q     <= StIdle;
               busy        <= 1'b0;
               isu_fifo_rd <= !isu_fifo_empty;
            end
            default: state_q <= StIdle;
         endcase
         if (go) begin
            cs_n                 <= 1'b0;
            {ras_n, cas_n, we_n} <= p_rcw;
            dram_addr            <= p_addr;
            dram_ba              <= p_ba;
            rd_issued            <= p_rd;
            wr_issued            <= p_wr;
         end
      end
   end

`ifdef CMD_ISSUER_SEQ_CHK_EN
   localparam int unsigned NumBanks = 1 << BA_BITS;

   logic [NumBanks-1:0] open_q;
   logic                seq_err_q;

   // Tracks the command on the pins this cycle; the offending command is never held back.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         open_q    <= '0;
         seq_err_q <= 1'b0;
      end else if (state_q == StIssue) begin
         case (cmd_q)
            CmdAct: begin
               if (open_q[ba_q]) seq_err_q <= 1'b1;
               open_q[ba_q] <= 1'b1;
            end
            CmdRd, CmdWr: if (!open_q[ba_q]) seq_err_q <= 1'b1;
            CmdPre, CmdRda, CmdWra: open_q[ba_q] <= 1'b0;
            CmdPrea: open_q <= '0;
            CmdRef: begin
               if (|open_q) seq_err_q <= 1'b1;
               open_q <= '0;
            end
            default: ;
         endcase
      end
   end

   assign seq_err = seq_err_q;
`else
   assign seq_err = 1'b0;
`endif

endmodule
